// File: rtl/alu_uart_iface_pkg.sv
// alu_uart_iface_pkg: FSM state encoding and ALU opcodes shared by the UART/ALU interface and its benches
package alu_uart_iface_pkg;
  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;
  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    EXEC    = ST_EXEC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
endpackage

// File: rtl/alu_iface_timer.sv
// alu_iface_timer: clearable up-counter flagging the cycle it reaches LIMIT-1
module alu_iface_timer #(
  parameter int LIMIT = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  // count up every cycle unless cleared
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  assign tc = cnt == W'(LIMIT - 1);
endmodule

// File: rtl/alu_uart_iface.sv
// alu_uart_iface: collects A/B/opcode bytes from uart_rx for the ALU and ships the result to uart_tx; define ALU_IFACE_TIMEOUT_EN for the inter-byte timeout
module alu_uart_iface
  import alu_uart_iface_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic [N_BITS-1:0] i_alu_res,
  input  logic              i_tx_done,
  output logic [N_BITS-1:0] o_alu_A,
  output logic [N_BITS-1:0] o_alu_B,
  output logic [N_BITS-1:0] o_alu_OP,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy
);
  state_t state;
  logic   timeout;
`ifdef ALU_IFACE_TIMEOUT_EN
  logic collecting, rx_accept;
  assign collecting = state == WAIT_B || state == WAIT_OP;
  assign rx_accept  = i_rx_done && (collecting || state == WAIT_A);
  alu_iface_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (rx_accept || !collecting),
    .tc   (timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  // frame FSM; a byte arriving in the same cycle as a timeout wins over the timeout
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state      <= WAIT_A;
      o_alu_A    <= '0;
      o_alu_B    <= '0;
      o_alu_OP   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        WAIT_A:
          if (i_rx_done) begin
            o_alu_A <= i_rx_data;
            state   <= WAIT_B;
          end
        WAIT_B:
          if (i_rx_done) begin
            o_alu_B <= i_rx_data;
            state   <= WAIT_OP;
          end else if (timeout) state <= WAIT_A;
        WAIT_OP:
          if (i_rx_done) begin
            o_alu_OP <= i_rx_data;
            o_busy   <= 1'b1;
            state    <= EXEC;
          end else if (timeout) state <= WAIT_A;
        EXEC: begin
          o_tx_data  <= i_alu_res;
          o_tx_start <= 1'b1;
          state      <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX:
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= WAIT_A;
          end
        default: begin
          o_busy <= 1'b0;
          state  <= WAIT_A;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_uart_iface.sv
// tb_alu_uart_iface: directed frames through alu_uart_iface with a behavioural ALU attached
module tb_alu_uart_iface;
  import alu_uart_iface_pkg::*;
  logic       clk = 1'b0, rst_n = 1'b0, rx_done = 1'b0, tx_done = 1'b0;
  logic [7:0] rx_data = '0, alu_res, alu_a, alu_b, alu_op, tx_data;
  logic       tx_start, busy;
  int         n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, b, op);
    case (op)
      {2'b00, OP_ADD}: return a + b;
      {2'b00, OP_SUB}: return a - b;
      {2'b00, OP_AND}: return a & b;
      {2'b00, OP_OR}:  return a | b;
      {2'b00, OP_XOR}: return a ^ b;
      {2'b00, OP_SRA}: return 8'($signed(a) >>> b);
      {2'b00, OP_SRL}: return a >> b;
      {2'b00, OP_NOR}: return ~(a | b);
      default:         return 8'h00;
    endcase
  endfunction
  assign alu_res = alu(alu_a, alu_b, alu_op);

  alu_uart_iface #(.N_BITS(8), .TIMEOUT_CYCLES(100)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx_data (rx_data),
    .i_rx_done (rx_done),
    .i_alu_res (alu_res),
    .i_tx_done (tx_done),
    .o_alu_A   (alu_a),
    .o_alu_B   (alu_b),
    .o_alu_OP  (alu_op),
    .o_tx_data (tx_data),
    .o_tx_start(tx_start),
    .o_busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a, b, op, exp);
    send_byte(a);
    send_byte(b);
    @(negedge clk);
    rx_data = op;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    chk("exec_start", tx_start, 0);
    chk("exec_busy", busy, 1);
    @(negedge clk);
    rx_done = 1'b0;
    @(posedge clk);
    #1;
    chk("send_start", tx_start, 1);
    chk("tx_data", tx_data, exp);
    @(posedge clk);
    #1;
    chk("wait_start", tx_start, 0);
    chk("wait_busy", busy, 1);
  endtask

  task automatic finish_tx;
    repeat (3) @(negedge clk);
    chk("hold_busy", busy, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int starts;
    #1;
    chk("rst_a", alu_a, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // ADD, SUB wrap, OR
    run_frame(8'h05, 8'h03, 8'h20, 8'h08);
    finish_tx();
    run_frame(8'h03, 8'h05, 8'h22, 8'hFE);
    finish_tx();
    run_frame(8'h0F, 8'hF0, 8'h25, 8'hFF);
    // byte in WAIT_TX and byte coincident with tx_done are both dropped
    send_byte(8'hAA);
    chk("drop_a", alu_a, 8'h0F);
    chk("drop_busy", busy, 1);
    @(negedge clk);
    tx_done = 1'b1;
    rx_data = 8'hBB;
    rx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    rx_done = 1'b0;
    chk("b2b_a", alu_a, 8'h0F);
    chk("b2b_busy", busy, 0);
    chk("hold_tx", tx_data, 8'hFF);
    run_frame(8'h01, 8'h01, 8'h24, 8'h01);
    chk("and_a", alu_a, 8'h01);
    chk("and_op", alu_op, 8'h24);
    finish_tx();
    // reset mid-frame clears everything at once and never fires tx_start
    send_byte(8'h11);
    send_byte(8'h22);
    chk("pre_rst_b", alu_b, 8'h22);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", alu_a, 0);
    chk("mid_rst_b", alu_b, 0);
    chk("mid_rst_op", alu_op, 0);
    chk("mid_rst_tx", tx_data, 0);
    starts = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      starts += int'(tx_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      starts += int'(tx_start);
    end
    chk("rst_no_start", starts, 0);
    run_frame(8'h09, 8'h04, 8'h26, 8'h0D);
    finish_tx();
    // inter-byte idle of 100 cycles
    send_byte(8'h07);
    repeat (100) @(posedge clk);
`ifdef ALU_IFACE_TIMEOUT_EN
    run_frame(8'h02, 8'h03, 8'h20, 8'h05);
    chk("to_a", alu_a, 8'h02);
    finish_tx();
`else
    send_byte(8'h02);
    send_byte(8'h03);
    @(posedge clk);
    #1;
    chk("noto_a", alu_a, 8'h07);
    chk("noto_b", alu_b, 8'h02);
    chk("noto_tx", tx_data, 8'h01);
    chk("noto_busy", busy, 1);
    send_byte(8'h20);
    chk("noto_op", alu_op, 8'h03);
    finish_tx();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_uart_iface.md
Name: alu_uart_iface

Overview:
- Sequential front/back end for the combinational ALU.
- Collects three bytes (operand A, operand B, opcode) from the UART receiver byte stream and drives them to the ALU operand/opcode inputs.
- Captures the ALU result and hands it to the UART transmitter with a start/done handshake.
- Sits between uart_rx, ALU and uart_tx in the board top level.

Parameters:
- N_BITS, 8, byte width of RX/TX data, operands, opcode and result.
- TIMEOUT_CYCLES, 50_000_000, inter-byte inactivity limit in clocks; used only when ALU_IFACE_TIMEOUT_EN is defined.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous, active-low reset
- i_rx_data  input  N_BITS  received byte, valid when i_rx_done=1
- i_rx_done  input  1  one-cycle pulse per received byte
- i_alu_res  input  N_BITS  ALU result, combinational from o_alu_A/B/OP
- i_tx_done  input  1  one-cycle pulse, transmitter finished the byte
- o_alu_A  output  N_BITS  latched operand A
- o_alu_B  output  N_BITS  latched operand B
- o_alu_OP  output  N_BITS  latched opcode byte (full byte, ALU decodes it)
- o_tx_data  output  N_BITS  registered result byte for transmitter
- o_tx_start  output  1  one-cycle transmit request
- o_busy  output  1  high in EXEC, SEND, WAIT_TX

Behaviour:
- Reset (async, i_rst_n=0): state=WAIT_A; o_alu_A/B/OP=0, o_tx_data=0, o_tx_start=0, o_busy=0, taking effect immediately. Reset mid-frame or mid-transmit discards the partial frame; no tx_start is issued afterwards.
- States and transitions:
  - WAIT_A: when i_rx_done=1, o_alu_A<=i_rx_data, go to WAIT_B.
  - WAIT_B: when i_rx_done=1, o_alu_B<=i_rx_data, go to WAIT_OP.
  - WAIT_OP: when i_rx_done=1, o_alu_OP<=i_rx_data, go to EXEC.
  - EXEC: exactly one cycle with operands stable at the ALU; o_tx_data<=i_alu_res at the closing edge; go to SEND.
  - SEND: o_tx_start=1 (Moore output, exactly one cycle); go to WAIT_TX.
  - WAIT_TX: when i_tx_done=1, go to WAIT_A; otherwise hold, with no limit.
- Latency: if the opcode byte's i_rx_done is sampled at edge N, o_tx_start is high during cycle N+2 and o_tx_data is valid from N+2.
- o_tx_data holds until the next EXEC.
- o_alu_A/B/OP hold their last latched values across frames until overwritten.
- i_rx_done in EXEC, SEND or WAIT_TX is dropped; the byte is lost and is not queued.
- i_tx_done outside WAIT_TX is ignored.
- Back-to-back: an i_rx_done in the cycle WAIT_TX exits is dropped. The first byte accepted is the one arriving once the state is WAIT_A.
- No width growth: result is N_BITS as delivered by the ALU, with no carry/overflow flag.

Optional Feature:
- Macro: ALU_IFACE_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and increments while the state is WAIT_B or WAIT_OP.
  - On reaching TIMEOUT_CYCLES-1 the state returns to WAIT_A.
  - Operand registers keep their values, but the partial frame is abandoned.
  - The counter is cleared in all other states and on reset.
- Undefined: no counter logic; WAIT_B and WAIT_OP wait indefinitely.
- Port list is identical in both builds.

Decomposition:
- Shared package:
  - state encoding localparams (WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX; 3-bit);
  - ALU opcode localparams (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111) for benches and top level.
- One natural sub-module: alu_iface_timer, a clearable up-counter with terminal-count output, instantiated only under ALU_IFACE_TIMEOUT_EN.

Test Plan:
- ADD frame: rx 0x05, 0x03, 0x20 with the real ALU attached -> o_tx_start one cycle, exactly 2 cycles after the third rx_done edge; o_tx_data=0x08; o_busy=1 through WAIT_TX.
- SUB wrap: rx 0x03, 0x05, 0x22 -> o_tx_data=0xFE.
- Second frame: rx 0x0F, 0xF0, 0x25 -> o_tx_data=0xFF.
- Dropped byte: inject rx_done(0xAA) while in WAIT_TX, then tx_done, then frame 0x01, 0x01, 0x24 -> o_alu_A=0x01, o_tx_data=0x01.
- Reset mid-frame: rx 0x11, 0x22, then assert i_rst_n=0 for 3 cycles -> all outputs 0 immediately, state WAIT_A, no o_tx_start. A following full frame processes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=100): rx 0x07, then idle 100 cycles -> back in WAIT_A. Next frame 0x02, 0x03, 0x20 -> o_tx_data=0x05. With the macro undefined, the same idle period leaves the block in WAIT_B.
